// File: rtl/sub_pkg.sv
// sub_pkg: shared nibble width and FSM state type for the serial borrow-lookahead subtractor
package sub_pkg;
  localparam int NIBW = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
endpackage

// File: rtl/bla_nibble.sv
// bla_nibble: combinational 4-bit borrow lookahead; a,b,bi -> d,bo plus group generate/propagate gg,gp
module bla_nibble
  import sub_pkg::*;
(
  input  logic [NIBW-1:0] a,
  input  logic [NIBW-1:0] b,
  input  logic            bi,
  output logic [NIBW-1:0] d,
  output logic            bo,
  output logic            gg,
  output logic            gp
);
  logic [NIBW-1:0] g, p;
  logic c1, c2, c3;
  assign g  = ~a & b;
  assign p  = ~(a ^ b);
  assign c1 = g[0] | p[0] & bi;
  assign c2 = g[1] | p[1] & g[0] | p[1] & p[0] & bi;
  assign c3 = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & bi;
  assign gg = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
  assign gp = &p;
  assign bo = gg | gp & bi;
  assign d  = a ^ b ^ {c3, c2, c1, bi};
endmodule

// File: rtl/serial_borrow_lookahead_subtractor.sv
// serial_borrow_lookahead_subtractor: diff = a - b - bin one nibble per clock; valid/ready in (a,b,bin) and out (diff,bout,ovf)
module serial_borrow_lookahead_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int NIB = WIDTH / NIBW;
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);
  if (WIDTH % NIBW != 0 || WIDTH < NIBW) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end
  sub_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic br_r;
  logic [NIBW-1:0] nib_d;
  logic nib_bo, unused_gg, unused_gp;
  bla_nibble u_nib (
    .a (a_r[{cnt, 2'b00} +: NIBW]),
    .b (b_r[{cnt, 2'b00} +: NIBW]),
    .bi(br_r),
    .d (nib_d),
    .bo(nib_bo),
    .gg(unused_gg),
    .gp(unused_gp)
  );
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (cnt == LAST ? DONE : RUN) :
              state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      br_r  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_r  <= a;
        b_r  <= b;
        br_r <= bin;
        cnt  <= '0;
      end
      if (state == RUN) begin
        diff[{cnt, 2'b00} +: NIBW] <= nib_d;
        br_r <= nib_bo;
        cnt  <= cnt + 1'b1;
        if (cnt == LAST) begin
          bout <= nib_bo;
          ovf  <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (nib_d[NIBW-1] ^ a_r[WIDTH-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_borrow_lookahead_subtractor.sv
// tb_serial_borrow_lookahead_subtractor: vector table, corner sequences and random scoreboard for the serial subtractor
module tb_serial_borrow_lookahead_subtractor;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, bin = 1'b0;
  logic out_valid, out_ready = 1'b0, bout, ovf;
  logic [15:0] a = '0, b = '0, diff;
  int total = 0, passed = 0;
  typedef struct {
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] d;
    logic        bo, ov;
  } vec_t;
  vec_t tbl[6];
  serial_borrow_lookahead_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                       output logic [15:0] md, output logic mbo, output logic mov);
    logic [16:0] full;
    int r;
    full = {1'b0, ma} - {1'b0, mb} - 17'(mbin);
    md   = full[15:0];
    mbo  = full[16];
    r    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    mov  = r < -32768 || r > 32767;
  endtask
  task automatic start(input logic [15:0] sa, input logic [15:0] sb, input logic sbin);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    a = sa;
    b = sb;
    bin = sbin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("done_timeout", 0, 1);
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic run_random(input logic [15:0] ra, input logic [15:0] rb, input logic rbin);
    logic [15:0] ed;
    logic eb, eo, done;
    int n = 0;
    model(ra, rb, rbin, ed, eb, eo);
    start(ra, rb, rbin);
    a = 16'($urandom);
    b = 16'($urandom);
    done = 1'b0;
    while (!done && n < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        chk("random", {14'd0, diff, bout, ovf}, {14'd0, ed, eb, eo});
        done = 1'b1;
      end
      tick();
      n++;
    end
    out_ready = 1'b0;
    if (!done) chk("random_timeout", 0, 1);
  endtask
  initial begin
    int lat;
    tbl[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    repeat (3) tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_outputs", {13'd0, out_valid, diff, bout, ovf}, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      start(tbl[i].a, tbl[i].b, tbl[i].bin);
      wait_done(lat);
      chk("latency", lat, 4);
      chk("vec_diff", diff, tbl[i].d);
      chk("vec_flags", {bout, ovf}, {tbl[i].bo, tbl[i].ov});
      release_out();
      chk("vec_back_idle", {out_valid, in_ready}, 2'b01);
    end
    start(16'h1234, 16'h0034, 1'b0);
    a = 16'hAAAA;
    b = 16'h5555;
    in_valid = 1'b1;
    chk("run_in_ready", in_ready, 0);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      chk("hold_result", {13'd0, diff, bout, ovf}, {13'd0, 16'h1200, 1'b0, 1'b0});
      chk("hold_in_ready", {out_valid, in_ready}, 2'b10);
      tick();
    end
    in_valid = 1'b0;
    release_out();
    chk("release_idle", {out_valid, in_ready}, 2'b01);
    start(16'h1111, 16'h0001, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    tick();
    chk("rst_abort", {out_valid, diff}, 0);
    rst = 1'b0;
    #1;
    chk("rst_recover", in_ready, 1);
    start(16'h00FF, 16'h000F, 1'b0);
    wait_done(lat);
    chk("post_rst_diff", diff, 16'h00F0);
    chk("post_rst_flags", {bout, ovf}, 2'b00);
    release_out();
    for (int i = 0; i < 10000; i++)
      run_random(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
